display_arbiter: RTL

//   Shares the 4-digit 7-segment panel (HEX3..HEX0) among N_REQ requesters, round-robin.

---
 rtl/display_pkg.sv | 43 ++++
 rtl/bcd_to_seg.sv | 20 ++
 rtl/display_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared constants, state encoding and helpers for the display arbiter.
package display_pkg;

    localparam int unsigned BCD_WIDTH = 16;
    localparam int unsigned SEG_WIDTH = 7;

    // Active-low segment patterns {g,f,e,d,c,b,a} for digits 0..9
    localparam logic [SEG_WIDTH-1:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam logic [SEG_WIDTH-1:0] SEG_DASH  = 7'b0111111;
    localparam logic [SEG_WIDTH-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_WIDTH-1:0] SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        UPDATE  = 2'd2,
        HOLD    = 2'd3
    } state_t;

    // Panel contents, HEX3 in the most significant slot
    typedef struct packed {
        logic [SEG_WIDTH-1:0] hex3;
        logic [SEG_WIDTH-1:0] hex2;
        logic [SEG_WIDTH-1:0] hex1;
        logic [SEG_WIDTH-1:0] hex0;
    } panel_t;

    // Double-dabble correction: add 3 to every nibble that is 5 or more
    function automatic logic [BCD_WIDTH-1:0] dabble_adjust(input logic [BCD_WIDTH-1:0] bcd);
        logic [BCD_WIDTH-1:0] res;
        res = bcd;
        for (int i = 0; i < 4; i++) begin
            if (res[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = res[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low 7-segment decoder with blanking.
module bcd_to_seg
    import display_pkg::*;
(
    input  logic [3:0]           i_bcd,
    input  logic                 i_blank,
    output logic [SEG_WIDTH-1:0] o_seg_c
);

    // Blank wins; values above 9 cannot be produced and show a dash
    always_comb begin
        o_seg_c = SEG_DASH;
        if (i_blank) begin
            o_seg_c = SEG_BLANK;
        end else if (i_bcd <= 4'd9) begin
            o_seg_c = SEG_DIGIT[i_bcd];
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin sharing of a 4-digit 7-segment panel among N_REQ requesters.
// The winner's 16-bit value is converted to BCD one bit per clock, shown,
// and held for HOLD_CYCLES before the next arbitration.
// Optional build macro: LEADING_BLANK_EN blanks leading zero digits HEX3..HEX1.
module display_arbiter
    import display_pkg::*;
#(
    parameter int unsigned N_REQ       = 2,
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned MAX_VAL     = 9999
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [16*N_REQ-1:0]        valor,
    output logic [N_REQ-1:0]           grant,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       busy,
    output logic [SEG_WIDTH-1:0]       HEX3,
    output logic [SEG_WIDTH-1:0]       HEX2,
    output logic [SEG_WIDTH-1:0]       HEX1,
    output logic [SEG_WIDTH-1:0]       HEX0
);

    localparam int unsigned OWN_W     = $clog2(N_REQ);
    localparam int unsigned VAL_W     = 16;
    localparam int unsigned BIT_CNT_W = 4;
    localparam int unsigned HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    // HOLD lasts HOLD_CYCLES clocks, but never less than one
    localparam int unsigned HOLD_LAST = (HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1;

    state_t                 r_state;
    state_t                 w_next_state;

    logic [VAL_W-1:0]       r_bin;
    logic [BCD_WIDTH-1:0]   r_bcd;
    logic                   r_over;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic [HOLD_W-1:0]      r_hold_cnt;
    logic [OWN_W-1:0]       r_last;
    logic [OWN_W-1:0]       r_owner;
    logic [N_REQ-1:0]       r_grant;
    logic                   r_busy;
    panel_t                 r_panel;

    logic                   w_found;
    logic [OWN_W-1:0]       w_winner;
    int unsigned            w_idx;
    logic [VAL_W-1:0]       w_cap_val;
    logic [BCD_WIDTH-1:0]   w_bcd_adj;
    logic                   w_capture;
    logic                   w_shift;
    logic                   w_update;
    logic                   w_hold_run;
    logic                   w_conv_done;
    logic                   w_hold_done;
    logic [3:0]             w_blank;
    logic [SEG_WIDTH-1:0]   w_seg [4];

    // Round-robin search: first asserted request after the last owner, wrapping
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            w_idx = 32'(r_last) + k;
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end
            if (!w_found && req[OWN_W'(w_idx)]) begin
                w_found  = 1'b1;
                w_winner = OWN_W'(w_idx);
            end
        end
    end

    // Select the winner's value for capture
    always_comb begin
        w_cap_val = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_winner == OWN_W'(i)) begin
                w_cap_val = valor[16*i +: 16];
            end
        end
    end

    assign w_bcd_adj   = dabble_adjust(r_bcd);
    assign w_conv_done = (r_bit_cnt == BIT_CNT_W'(15));
    assign w_hold_done = (r_hold_cnt >= HOLD_W'(HOLD_LAST));

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_found)     w_next_state = CONVERT;
            CONVERT: if (w_conv_done) w_next_state = UPDATE;
            UPDATE:                   w_next_state = HOLD;
            HOLD:    if (w_hold_done) w_next_state = IDLE;
            default:                  w_next_state = IDLE;
        endcase
    end

    // FSM per-state datapath enables
    always_comb begin
        w_capture  = 1'b0;
        w_shift    = 1'b0;
        w_update   = 1'b0;
        w_hold_run = 1'b0;
        case (r_state)
            IDLE:    w_capture  = w_found;
            CONVERT: w_shift    = 1'b1;
            UPDATE:  w_update   = 1'b1;
            HOLD:    w_hold_run = 1'b1;
            default: ;
        endcase
    end

    // Capture, arbitration pointer, grant pulse and double-dabble shifter
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bin     <= '0;
            r_bcd     <= '0;
            r_over    <= 1'b0;
            r_bit_cnt <= '0;
            r_owner   <= '0;
            r_last    <= OWN_W'(N_REQ - 1);
            r_grant   <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_grant <= '0;
            r_busy  <= (w_next_state != IDLE);
            if (w_capture) begin
                r_bin     <= w_cap_val;
                r_bcd     <= '0;
                r_over    <= (w_cap_val > VAL_W'(MAX_VAL));
                r_bit_cnt <= '0;
                r_owner   <= w_winner;
                r_last    <= w_winner;
                r_grant   <= N_REQ'(1) << w_winner;
            end
            if (w_shift) begin
                r_bcd     <= {w_bcd_adj[BCD_WIDTH-2:0], r_bin[VAL_W-1]};
                r_bin     <= {r_bin[VAL_W-2:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                // A carry out of the thousands digit means the value exceeds 9999
                r_over    <= r_over | w_bcd_adj[BCD_WIDTH-1];
            end
        end
    end

    // Minimum display time counter, cleared outside HOLD
    always_ff @(posedge clock) begin
        if (reset || !w_hold_run) begin
            r_hold_cnt <= '0;
        end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        end
    end

`ifdef LEADING_BLANK_EN
    // Blank leading zeros down to, but never including, the units digit
    assign w_blank[3] = (r_bcd[15:12] == 4'd0);
    assign w_blank[2] = w_blank[3] && (r_bcd[11:8] == 4'd0);
    assign w_blank[1] = w_blank[2] && (r_bcd[7:4] == 4'd0);
`else
    assign w_blank[3:1] = 3'b000;
`endif
    assign w_blank[0] = 1'b0;

    for (genvar d = 0; d < 4; d++) begin : g_digit
        bcd_to_seg u_seg (
            .i_bcd   (r_bcd[4*d +: 4]),
            .i_blank (w_blank[d]),
            .o_seg_c (w_seg[d])
        );
    end

    // Panel registers load once per conversion, dashes for out-of-range values
    always_ff @(posedge clock) begin
        if (reset) begin
            r_panel <= {SEG_ZERO, SEG_ZERO, SEG_ZERO, SEG_ZERO};
        end else if (w_update) begin
            if (r_over) begin
                r_panel <= {SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH};
            end else begin
                r_panel <= {w_seg[3], w_seg[2], w_seg[1], w_seg[0]};
            end
        end
    end

    assign grant = r_grant;
    assign owner = r_owner;
    assign busy  = r_busy;
    assign HEX3  = r_panel.hex3;
    assign HEX2  = r_panel.hex2;
    assign HEX1  = r_panel.hex1;
    assign HEX0  = r_panel.hex0;

endmodule
